// File: rtl/exe_ctrl.sv
// Handshaked control stage around a combinational execution unit: registers commands,
// captures result/flags, reports illegal opcodes, counts deliveries. Optional EXE_CTRL_STICKY_EN.
module exe_ctrl #(
   parameter int M  = 8,
   parameter int N  = 4,
   parameter int CW = 16
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_valid,
   output logic          o_ready,
   input  logic [M-1:0]  i_argA,
   input  logic [M-1:0]  i_argB,
   input  logic [N-1:0]  i_oper,
   output logic [M-1:0]  o_exe_argA,
   output logic [M-1:0]  o_exe_argB,
   output logic [N-1:0]  o_exe_oper,
   input  logic [M-1:0]  i_exe_result,
   input  logic          i_exe_VF,
   input  logic          i_exe_ZF,
   input  logic          i_exe_PF,
   input  logic          i_exe_BF,
   output logic          o_valid,
   input  logic          i_ready,
   output logic [M-1:0]  o_result,
   output logic          o_VF,
   output logic          o_ZF,
   output logic          o_PF,
   output logic          o_BF,
   output logic          o_err,
   output logic [CW-1:0] o_cnt,
   input  logic          i_clr,
   output logic [3:0]    o_sticky
);

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      EXEC = 2'b01,
      DONE = 2'b10
   } state_t;

   state_t        state_r;
   state_t        next_state_s;
   logic          ready_s;
   logic          load_s;
   logic          capture_s;
   logic          hs_s;
   logic          valid_r;
   logic [CW-1:0] cnt_r;

   function automatic logic is_illegal(input logic [N-1:0] op);
      return (op == N'(4'hA)) || (op == N'(4'hD)) || (op == N'(4'hE)) || (op == N'(4'hF));
   endfunction

   // State register
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state and handshake decode; DONE passes downstream ready straight through
   always_comb begin
      next_state_s = state_r;
      ready_s      = 1'b0;
      load_s       = 1'b0;
      capture_s    = 1'b0;
      case (state_r)
         IDLE: begin
            ready_s = 1'b1;
            if (i_valid) begin
               load_s       = 1'b1;
               next_state_s = EXEC;
            end else begin
               next_state_s = IDLE;
            end
         end
         EXEC: begin
            capture_s    = 1'b1;
            next_state_s = DONE;
         end
         DONE: begin
            ready_s = i_ready;
            if (i_ready) begin
               if (i_valid) begin
                  load_s       = 1'b1;
                  next_state_s = EXEC;
               end else begin
                  next_state_s = IDLE;
               end
            end else begin
               next_state_s = DONE;
            end
         end
         default: begin
            next_state_s = IDLE;
         end
      endcase
   end

   assign hs_s    = valid_r & i_ready;
   assign o_ready = ready_s;
   assign o_valid = valid_r;
   assign o_cnt   = cnt_r;

   // Command registers feeding the execution unit
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_exe_argA <= '0;
         o_exe_argB <= '0;
         o_exe_oper <= '0;
      end else if (load_s) begin
         o_exe_argA <= i_argA;
         o_exe_argB <= i_argB;
         o_exe_oper <= i_oper;
      end
   end

   // Result capture; values are held after delivery until the next EXEC
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_result <= '0;
         o_VF     <= 1'b0;
         o_ZF     <= 1'b0;
         o_PF     <= 1'b0;
         o_BF     <= 1'b0;
         o_err    <= 1'b0;
      end else if (capture_s) begin
         o_result <= i_exe_result;
         o_VF     <= i_exe_VF;
         o_ZF     <= i_exe_ZF;
         o_PF     <= i_exe_PF;
         o_BF     <= i_exe_BF;
         o_err    <= is_illegal(o_exe_oper);
      end
   end

   // Output valid and delivered-result counter (wraps naturally)
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         valid_r <= 1'b0;
         cnt_r   <= '0;
      end else begin
         valid_r <= (next_state_s == DONE);
         if (hs_s) begin
            cnt_r <= cnt_r + CW'(1);
         end
      end
   end

`ifdef EXE_CTRL_STICKY_EN
   logic [3:0] sticky_r;

   // Sticky flags; a clear in the same cycle as a capture wins
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sticky_r <= 4'b0000;
      end else if (i_clr) begin
         sticky_r <= 4'b0000;
      end else if (capture_s) begin
         sticky_r <= sticky_r | {i_exe_VF, i_exe_ZF, i_exe_PF, i_exe_BF};
      end
   end

   assign o_sticky = sticky_r;
`else
   logic unused_clr_s;

   assign unused_clr_s = i_clr;
   assign o_sticky     = 4'b0000;
`endif

endmodule

// File: tb/tb_exe_ctrl.sv
// Randomized self-checking bench for exe_ctrl with a transaction-level reference model
// and a simple combinational stand-in for the execution unit.
module tb_exe_ctrl;

   logic       clk = 1'b0;
   logic       rst_n, valid_in, ready_in, clr;
   logic [7:0] arg_a, arg_b;
   logic [3:0] oper;
   logic       ready_out, valid_out;
   logic [7:0] exe_a, exe_b, exe_res, res;
   logic [3:0] exe_op;
   logic       exe_vf, exe_zf, exe_pf, exe_bf;
   logic       vf, zf, pf, bf, err;
   logic [3:0] cnt;
   logic [3:0] sticky;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   exe_ctrl #(.M(8), .N(4), .CW(4)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid_in), .o_ready(ready_out),
      .i_argA(arg_a), .i_argB(arg_b), .i_oper(oper),
      .o_exe_argA(exe_a), .o_exe_argB(exe_b), .o_exe_oper(exe_op),
      .i_exe_result(exe_res), .i_exe_VF(exe_vf), .i_exe_ZF(exe_zf),
      .i_exe_PF(exe_pf), .i_exe_BF(exe_bf),
      .o_valid(valid_out), .i_ready(ready_in), .o_result(res),
      .o_VF(vf), .o_ZF(zf), .o_PF(pf), .o_BF(bf), .o_err(err),
      .o_cnt(cnt), .i_clr(clr), .o_sticky(sticky)
   );

   // Stand-in execution unit: returns {result, VF, ZF, PF, BF}
   function automatic logic [11:0] unit(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
      logic [8:0] sum;
      logic [7:0] r;
      logic       v, bo;
      sum = {1'b0, a} + {1'b0, b};
      v   = 1'b0;
      case (op)
         4'h0: r = sum[7:0];
         4'h1: r = a ^ b;
         4'h2: r = a & b;
         4'h3: r = a | b;
         4'hA, 4'hD, 4'hE, 4'hF: r = 8'h00;
         default: r = {a[3:0], b[7:4]} ^ {4'h0, op};
      endcase
      if (op == 4'h0) begin
         v  = sum[8];
         bo = sum[8];
      end else begin
         bo = r[7];
      end
      return {r, v, (r == 8'h00), ^r, bo};
   endfunction

   always_comb {exe_res, exe_vf, exe_zf, exe_pf, exe_bf} = unit(exe_a, exe_b, exe_op);

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
   endtask

   // Reference model state: one command in flight, accepted at edge acc_e
   bit         pend;
   int         e, acc_e;
   logic [7:0] m_a, m_b, m_res;
   logic [3:0] m_op, m_cnt, m_sticky;
   logic       m_vf, m_zf, m_pf, m_bf, m_err;

   task automatic model_reset();
      pend = 1'b0; acc_e = 0;
      m_a = 8'h00; m_b = 8'h00; m_op = 4'h0; m_res = 8'h00;
      {m_vf, m_zf, m_pf, m_bf, m_err} = 5'b00000;
      m_cnt = 4'h0; m_sticky = 4'h0;
   endtask

   // Drive one cycle, compare outputs against the model, then advance the model across the edge
   task automatic step(input logic v, input logic r, input logic [7:0] a, input logic [7:0] b,
                       input logic [3:0] op, input logic c, input logic rn, input bit chk);
      bit ev, er, hs, acc, cap;
      logic [11:0] u;
      valid_in = v; ready_in = r; arg_a = a; arg_b = b; oper = op; clr = c; rst_n = rn;
      #1;
      ev = pend && (e > acc_e);
      er = !pend || (ev && r);
      if (chk) begin
         check_eq("o_valid", 32'(valid_out), 32'(ev));
         check_eq("o_ready", 32'(ready_out), 32'(er));
         check_eq("o_cnt", 32'(cnt), 32'(m_cnt));
         check_eq("o_sticky", 32'(sticky), 32'(m_sticky));
         check_eq("exe_cmd", {12'h000, exe_a, exe_b, exe_op}, {12'h000, m_a, m_b, m_op});
         check_eq("o_result", 32'(res), 32'(m_res));
         check_eq("flags_err", 32'({vf, zf, pf, bf, err}), 32'({m_vf, m_zf, m_pf, m_bf, m_err}));
      end
      @(posedge clk);
      hs  = ev && r;
      acc = v && er;
      cap = pend && (e == acc_e);
      e++;
      if (!rn) begin
         model_reset();
      end else begin
         if (cap) begin
            u = unit(m_a, m_b, m_op);
            {m_res, m_vf, m_zf, m_pf, m_bf} = u;
            m_err = (m_op inside {4'hA, 4'hD, 4'hE, 4'hF});
         end
`ifdef EXE_CTRL_STICKY_EN
         if (c) m_sticky = 4'h0;
         else if (cap) m_sticky = m_sticky | {m_vf, m_zf, m_pf, m_bf};
`endif
         if (hs) begin
            m_cnt = m_cnt + 4'h1;
            pend  = 1'b0;
         end
         if (acc) begin
            pend = 1'b1; acc_e = e;
            m_a = a; m_b = b; m_op = op;
         end
      end
      @(negedge clk);
   endtask

   initial begin
      e = 0;
      model_reset();
      valid_in = 1'b0; ready_in = 1'b0; arg_a = 8'h00; arg_b = 8'h00; oper = 4'h0;
      clr = 1'b0; rst_n = 1'b0;
      @(negedge clk);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      // ADD with overflow
      step(1'b1, 1'b0, 8'hF0, 8'h20, 4'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      // XOR to zero, then backpressure for 5 cycles
      step(1'b1, 1'b0, 8'hA5, 8'hA5, 4'h1, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'h11, 8'h22, 4'h2, 1'b0, 1'b1, 1'b1);
      // Back-to-back accept of an illegal opcode
      step(1'b1, 1'b1, 8'h3C, 8'h00, 4'hF, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b1, 8'h00, 8'h00, 4'h0, 1'b1, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      // Reset while in EXEC
      step(1'b1, 1'b0, 8'h55, 8'h0F, 4'h3, 1'b0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 8'h00, 8'h00, 4'h0, 1'b0, 1'b1, 1'b1);
      // Sustained traffic: 17 handshakes wrap the 4-bit counter
      for (int i = 0; i < 36; i++)
         step(1'b1, 1'b1, 8'(i * 7), 8'(i * 13), 4'(i), 1'b0, 1'b1, 1'b1);
      // Random traffic with occasional clears and resets
      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 8'($urandom), 8'($urandom),
              4'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 59) != 0, 1'b1);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
